// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter: two-master round-robin Wishbone arbiter with a slave-stall watchdog
// Grant is held for the owner's whole cyc; a stalled slave yields a one-cycle err to the owner.
module wb_master_arbiter #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic        wb_clk_i,
   input  logic        reset,
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   input  logic        m0_we_i,
   input  logic [3:0]  m0_sel_i,
   input  logic [31:0] m0_adr_i,
   input  logic [31:0] m0_dat_i,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   output logic [31:0] m0_dat_o,
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_sel_i,
   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic [31:0] m1_dat_o,
   output logic        s_cyc_o,
   output logic        s_stb_o,
   output logic        s_we_o,
   output logic [3:0]  s_sel_o,
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   input  logic        s_ack_i,
   input  logic [31:0] s_dat_i,
   output logic [1:0]  grant_o,
   output logic        timeout_o
);
   typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;
   localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
   state_t state, state_nxt;
   logic owner, owner_nxt, last, last_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic req0, req1, own_cyc, own_stb, busy, ack_ok, err_ok;
   assign req0    = m0_cyc_i & m0_stb_i;
   assign req1    = m1_cyc_i & m1_stb_i;
   assign own_cyc = owner ? m1_cyc_i : m0_cyc_i;
   assign own_stb = owner ? m1_stb_i : m0_stb_i;
   assign busy    = state == BUSY;
   always_ff @(posedge wb_clk_i)
      if (reset) begin
         state <= IDLE;
         owner <= 1'b0;
         last  <= 1'b1;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
         last  <= last_nxt;
         cnt   <= cnt_nxt;
      end
   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      last_nxt  = last;
      cnt_nxt   = '0;
      case (state)
         IDLE: if (req0 | req1) begin
            state_nxt = BUSY;
            owner_nxt = (req0 & req1) ? ~last : req1;
         end
         BUSY: begin
            if (!own_cyc) begin
               state_nxt = IDLE;
               last_nxt  = owner;
            end else if (own_stb && !s_ack_i && cnt == TMO)
               state_nxt = ERR;
            cnt_nxt = s_ack_i ? '0 : (own_stb && cnt != TMO) ? cnt + CNT_W'(1) : cnt;
         end
         default: begin
            state_nxt = IDLE;
            last_nxt  = owner;
         end
      endcase
   end
   assign s_cyc_o   = busy & own_cyc;
   assign s_stb_o   = busy & own_stb;
   assign s_we_o    = busy & (owner ? m1_we_i : m0_we_i);
   assign s_sel_o   = busy ? (owner ? m1_sel_i : m0_sel_i) : '0;
   assign s_adr_o   = busy ? (owner ? m1_adr_i : m0_adr_i) : '0;
   assign s_dat_o   = busy ? (owner ? m1_dat_i : m0_dat_i) : '0;
   assign grant_o   = (state == IDLE) ? 2'b00 : {owner, ~owner};
   // Responses are suppressed while reset is pending so an aborted owner sees neither ack nor err.
   assign ack_ok    = busy & s_ack_i & ~reset;
   assign err_ok    = (state == ERR) & ~reset;
   assign timeout_o = err_ok;
   assign m0_ack_o  = ack_ok & ~owner;
   assign m1_ack_o  = ack_ok & owner;
   assign m0_err_o  = err_ok & ~owner;
   assign m1_err_o  = err_ok & owner;
   assign m0_dat_o  = (busy & ~owner) ? s_dat_i : '0;
   assign m1_dat_o  = (busy & owner) ? s_dat_i : '0;
endmodule

// File: tb/tb_wb_master_arbiter.sv
// tb_wb_master_arbiter: directed bench for wb_master_arbiter with TIMEOUT=4
module tb_wb_master_arbiter;
   logic        wb_clk_i = 1'b0;
   logic        reset = 1'b1;
   logic        m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
   logic [3:0]  m0_sel_i, m1_sel_i;
   logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
   logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
   logic [31:0] m0_dat_o, m1_dat_o;
   logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i;
   logic [3:0]  s_sel_o;
   logic [31:0] s_adr_o, s_dat_o, s_dat_i;
   logic [1:0]  grant_o;
   logic        timeout_o;
   int          checks = 0, errors = 0;
   logic        exp_own;
   int          n0;

   wb_master_arbiter #(.TIMEOUT(4), .CNT_W(3)) dut (
      .wb_clk_i(wb_clk_i), .reset(reset),
      .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
      .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
      .m0_dat_o(m0_dat_o),
      .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
      .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
      .m1_dat_o(m1_dat_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
      .grant_o(grant_o), .timeout_o(timeout_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic sample;
      @(negedge wb_clk_i);
   endtask

   task automatic req(input int n, input logic on, input logic we, input logic [31:0] adr, input logic [31:0] dat);
      if (n == 0) begin
         m0_cyc_i = on; m0_stb_i = on; m0_we_i = we; m0_sel_i = 4'hf; m0_adr_i = adr; m0_dat_i = dat;
      end else begin
         m1_cyc_i = on; m1_stb_i = on; m1_we_i = we; m1_sel_i = 4'hf; m1_adr_i = adr; m1_dat_i = dat;
      end
   endtask

   initial begin
      req(0, 0, 0, 0, 0);
      req(1, 0, 0, 0, 0);
      s_ack_i = 1'b0;
      s_dat_i = '0;
      tick; tick; sample;
      check("rst_grant", grant_o, 0);
      check("rst_scyc", s_cyc_o, 0);
      check("rst_tmo", timeout_o, 0);
      // single read by m0
      tick; reset = 1'b0; req(0, 1, 0, 32'h30000004, 0);
      sample; check("t1_pre_grant", grant_o, 0);
      tick; sample;
      check("t1_grant", grant_o, 2'b01);
      check("t1_sadr", s_adr_o, 32'h30000004);
      check("t1_sstb", s_stb_o, 1);
      tick; sample; check("t1_stall_ack", m0_ack_o, 0);
      tick; s_ack_i = 1'b1; s_dat_i = 32'h4669626f; sample;
      check("t1_ack", m0_ack_o, 1);
      check("t1_dat", m0_dat_o, 32'h4669626f);
      check("t1_m1_ack", m1_ack_o, 0);
      check("t1_m1_dat", m1_dat_o, 0);
      check("t1_err", m0_err_o, 0);
      tick; s_ack_i = 1'b0; req(0, 0, 0, 0, 0); sample;
      check("t1_cyc_drop", s_cyc_o, 0);
      tick; sample; check("t1_idle", grant_o, 0);
      // simultaneous requests right after reset
      tick; reset = 1'b1;
      tick; reset = 1'b0; req(0, 1, 0, 32'h30000000, 0); req(1, 1, 1, 32'h30000008, 32'h12345678);
      tick; s_ack_i = 1'b1; sample;
      check("t2_grant0", grant_o, 2'b01);
      check("t2_m0_ack", m0_ack_o, 1);
      check("t2_m1_ack", m1_ack_o, 0);
      tick; s_ack_i = 1'b0; req(0, 0, 0, 0, 0); sample;
      check("t2_drop_grant", grant_o, 2'b01);
      check("t2_drop_scyc", s_cyc_o, 0);
      tick; sample; check("t2_gap", grant_o, 0);
      tick; s_ack_i = 1'b1; sample;
      check("t2_grant1", grant_o, 2'b10);
      check("t2_swe", s_we_o, 1);
      check("t2_sadr", s_adr_o, 32'h30000008);
      check("t2_sdat", s_dat_o, 32'h12345678);
      check("t2_m1_ack", m1_ack_o, 1);
      check("t2_m0_ack_off", m0_ack_o, 0);
      tick; s_ack_i = 1'b0; req(1, 0, 0, 0, 0);
      tick;
      // continuous contention: grants must alternate
      req(0, 1, 0, 32'h30000020, 0); req(1, 1, 0, 32'h30000024, 0);
      exp_own = 1'b0;
      n0 = 0;
      for (int i = 0; i < 16; i++) begin
         tick; s_ack_i = 1'b1; sample;
         check("t3_grant", grant_o, exp_own ? 2'b10 : 2'b01);
         check("t3_ack", exp_own ? m1_ack_o : m0_ack_o, 1);
         if (grant_o == 2'b01) n0++;
         tick; s_ack_i = 1'b0;
         if (exp_own) req(1, 0, 0, 0, 0); else req(0, 0, 0, 0, 0);
         tick;
         if (exp_own) req(1, 1, 0, 32'h30000024, 0); else req(0, 1, 0, 32'h30000020, 0);
         exp_own = ~exp_own;
      end
      check("t3_m0_share", n0, 8);
      req(0, 0, 0, 0, 0); req(1, 0, 0, 0, 0);
      // watchdog abort: stalls at cnt 0..4, ERR on the next cycle
      req(0, 1, 0, 32'h3000000c, 0);
      tick;
      for (int k = 0; k < 5; k++) begin
         sample;
         check("t4_stall_err", m0_err_o, 0);
         check("t4_stall_tmo", timeout_o, 0);
         tick;
      end
      sample;
      check("t4_err", m0_err_o, 1);
      check("t4_tmo", timeout_o, 1);
      check("t4_scyc", s_cyc_o, 0);
      check("t4_ack", m0_ack_o, 0);
      check("t4_m1_err", m1_err_o, 0);
      req(0, 0, 0, 0, 0);
      tick; sample;
      check("t4_idle", grant_o, 0);
      check("t4_tmo_pulse", timeout_o, 0);
      check("t4_err_pulse", m0_err_o, 0);
      // ack lands exactly at cnt==TIMEOUT
      req(1, 1, 0, 32'h30000010, 0);
      tick;
      for (int k = 0; k < 4; k++) begin
         sample;
         check("t5_stall_err", m1_err_o, 0);
         tick;
      end
      s_ack_i = 1'b1; s_dat_i = 32'h00000055; sample;
      check("t5_ack", m1_ack_o, 1);
      check("t5_dat", m1_dat_o, 32'h00000055);
      check("t5_err", m1_err_o, 0);
      check("t5_tmo", timeout_o, 0);
      tick; s_ack_i = 1'b0; sample;
      check("t5_no_err", m1_err_o, 0);
      check("t5_no_tmo", timeout_o, 0);
      check("t5_hold", grant_o, 2'b10);
      req(1, 0, 0, 0, 0);
      tick;
      // reset while m1 owns a write
      req(1, 1, 1, 32'h30000018, 32'hdeadbeef);
      tick; sample;
      check("t6_grant", grant_o, 2'b10);
      check("t6_sadr", s_adr_o, 32'h30000018);
      check("t6_swe", s_we_o, 1);
      tick; reset = 1'b1; s_ack_i = 1'b1; sample;
      check("t6_rst_ack", m1_ack_o, 0);
      tick; s_ack_i = 1'b0; req(0, 1, 0, 32'h30000000, 0); sample;
      check("t6_grant_rst", grant_o, 0);
      check("t6_scyc_rst", s_cyc_o, 0);
      check("t6_ack_rst", m1_ack_o, 0);
      check("t6_err_rst", m1_err_o, 0);
      tick; reset = 1'b0;
      tick; sample;
      check("t6_tie_m0", grant_o, 2'b01);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
